dct_serial_mac: RTL and testbench
=================================

// Module: dct_serial_mac
// PURPOSE
// - Bit-serial multiply-accumulate stage of the DCT datapath, directly downstream of the 24-to-1 bit-select mux.
// - Drives the 5-bit mux select to walk each 24-bit two's-complement sample LSB-first, consuming one serial bit per cycle.
// - Accumulates coef*sample over N_TERMS samples and emits one signed DCT partial sum per start.
// PARAMETERS
// WORD_W   24  sample width; bits per serial word; max 32, since sel is 5 bits
// COEF_W   12  signed coefficient width
// N_TERMS  8   products summed per result
// ACC_W    WORD_W+COEF_W+$clog2(N_TERMS) (=39)  accumulator/result width
// PORTS
// clk         in   1       rising-edge clock
// rst_n       in   1       asynchronous, active-low reset
// start       in   1       begin new accumulation; sampled only in IDLE
// serial_bit  in   1       mux output: bit [sel] of sample [term_idx]
// coef        in   COEF_W  signed coefficient for term_idx, stable while term_idx is held
// sel         out  5       bit index to mux {s4..s0}, registered
// term_idx    out  $clog2(N_TERMS)  sample/coef index requested from upstream, registered
// busy        out  1       high in RUN
// result      out  ACC_W   signed sum, valid when done; held until the next start
// done        out  1       one-cycle pulse, result valid
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE; sel=0, term_idx=0, busy=0, done=0, result=0, acc=0.
// - FSM states:
//   - IDLE: start=1 -> RUN, acc=0, sel=0, term_idx=0, busy=1.
//   - RUN: each cycle samples serial_bit against the current sel/term_idx. Mux is combinational, so there are zero cycles from sel to bit.
//   - DONE: single cycle; result<=acc, done=1, busy=0 -> IDLE.
// - RUN accumulate rule, per cycle with b=sel:
//   - if serial_bit, acc += sext(coef)<<b for b<WORD_W-1;
//   - for b=WORD_W-1 (sign bit), acc -= sext(coef)<<b.
//   - All arithmetic is signed, full ACC_W width; no saturation; overflow impossible by width choice.
// - Counters:
//   - sel counts 0..WORD_W-1, then wraps to 0 and term_idx increments.
//   - At sel=WORD_W-1 and term_idx=N_TERMS-1 -> DONE.
//   - Values 24..31 are never driven on sel.
// - Latency: start accepted at edge k -> done high in cycle k+N_TERMS*WORD_W+1 (193 cycles for the default parameters).
// - Simultaneous events:
//   - start while busy or in DONE is ignored, never queued.
//   - start in the cycle after done begins a new run normally.
// - Reset mid-run: aborts immediately; done never pulses; result returns to 0.
// - done and busy are never high together; result changes only in DONE or on reset.
// STRUCTURE
// - Shared package dct_pkg:
//   - constants WORD_W=24, COEF_W=12, N_TERMS=8;
//   - state enum {IDLE, RUN, DONE};
//   - function acc_w() computing ACC_W.
// - One natural sub-module: dct_bitsel_counter (sel/term_idx counter with wrap and last-bit flag).
// - Accumulator and FSM stay in the top.
// - Instantiated beside the existing 24-to-1 mux: sel -> {s4,s3,s2,s1,s0}, mux out -> serial_bit.
// TESTING
// - Bench model: 8x24-bit sample array plus a behavioural 24:1 mux.
// - T1 all samples=1, all coefs=1, pulse start -> sel cycles 0..23 eight times, term_idx 0..7; done at cycle 193; result=8.
// - T2 sample0=0x800000, coef0=2047, others 0 -> result=-17171480576 (sign-bit subtract path).
// - T3 all samples=0x7FFFFF, all coefs=-2048 -> result=-137438937088 (near full-scale, no wrap).
// - T4 start re-pulsed at cycles 5 and 100 of a run -> ignored, single done at 193, result matches T1 stimulus.
// - T5 rst_n low at cycle 50 of a run -> busy=0, sel=0, result=0 asynchronously, no done; the next start gives the correct result.
// - T6 back-to-back: start in the cycle after done -> second result correct, result holds the first value until the second done.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared constants, state encoding and width helper for the bit-serial DCT MAC.
package dct_pkg;

  localparam int WORD_W  = 24;
  localparam int COEF_W  = 12;
  localparam int N_TERMS = 8;
  localparam int TERM_W  = $clog2(N_TERMS);

  // Accumulator width: product width plus growth for summing N_TERMS products.
  function automatic int acc_w();
    return WORD_W + COEF_W + $clog2(N_TERMS);
  endfunction

  localparam int ACC_W = acc_w();

  localparam logic [4:0]        SEL_LAST  = 5'(WORD_W - 1);
  localparam logic [TERM_W-1:0] TERM_LAST = TERM_W'(N_TERMS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/dct_bitsel_counter.sv
// Walks the mux select LSB-first through each sample word, then steps to the
// next term; flags the final bit of the final term.
module dct_bitsel_counter
  import dct_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              advance,
  output logic [4:0]        sel,
  output logic [TERM_W-1:0] term_idx,
  output logic              last
);

  assign last = (sel == SEL_LAST) && (term_idx == TERM_LAST);

  // Bit index wraps at the word's sign bit and carries into the term index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel      <= '0;
      term_idx <= '0;
    end else if (clear) begin
      sel      <= '0;
      term_idx <= '0;
    end else if (advance) begin
      if (sel == SEL_LAST) begin
        sel <= '0;
        if (term_idx == TERM_LAST) begin
          term_idx <= '0;
        end else begin
          term_idx <= term_idx + TERM_W'(1);
        end
      end else begin
        sel <= sel + 5'd1;
      end
    end
  end

endmodule

// File: rtl/dct_serial_mac.sv
// Bit-serial multiply-accumulate: consumes one sample bit per cycle from the
// upstream 24:1 mux and sums coef*sample over N_TERMS terms.
module dct_serial_mac
  import dct_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    serial_bit,
  input  logic signed [COEF_W-1:0] coef,
  output logic [4:0]              sel,
  output logic [TERM_W-1:0]       term_idx,
  output logic                    busy,
  output logic signed [ACC_W-1:0] result,
  output logic                    done
);

  state_t                  state;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] coef_ext;
  logic signed [ACC_W-1:0] addend;
  logic                    cnt_clear;
  logic                    cnt_advance;
  logic                    cnt_last;

  assign cnt_clear   = (state == IDLE) && start;
  assign cnt_advance = (state == RUN);
  assign coef_ext    = {{(ACC_W - COEF_W){coef[COEF_W-1]}}, coef};
  assign addend      = coef_ext <<< sel;

  dct_bitsel_counter u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (cnt_clear),
    .advance  (cnt_advance),
    .sel      (sel),
    .term_idx (term_idx),
    .last     (cnt_last)
  );

  // Control FSM and accumulator; the sign bit of each word carries negative weight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      acc    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            acc   <= '0;
          end
        end
        RUN: begin
          if (serial_bit) begin
            if (sel == SEL_LAST) begin
              acc <= acc - addend;
            end else begin
              acc <= acc + addend;
            end
          end
          if (cnt_last) begin
            state <= DONE;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          result <= acc;
          done   <= 1'b1;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dct_serial_mac.sv
// Self-checking bench for dct_serial_mac: behavioural sample array and 24:1 mux
// feed the DUT, and an integer dot-product model supplies expected results.
module tb_dct_serial_mac;
  import dct_pkg::*;

  localparam int LATENCY = N_TERMS * WORD_W + 1;
  localparam int LIMIT   = 400;

  logic                     clk;
  logic                     rst_n;
  logic                     start;
  logic                     serial_bit;
  logic signed [COEF_W-1:0] coef;
  logic [4:0]               sel;
  logic [TERM_W-1:0]        term_idx;
  logic                     busy;
  logic signed [ACC_W-1:0]  result;
  logic                     done;

  logic signed [WORD_W-1:0] samples [N_TERMS];
  logic signed [COEF_W-1:0] coefs   [N_TERMS];

  int checks = 0;
  int passes = 0;

  dct_serial_mac dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .serial_bit (serial_bit),
    .coef       (coef),
    .sel        (sel),
    .term_idx   (term_idx),
    .busy       (busy),
    .result     (result),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural mux: the selected bit of the requested sample, zero off the end.
  always_comb begin
    serial_bit = 1'b0;
    if (sel < 5'd24) serial_bit = samples[term_idx][sel];
    coef = coefs[term_idx];
  end

  // Reference: plain signed dot product of samples and coefficients.
  function automatic logic signed [ACC_W-1:0] model_result();
    longint s = 0;
    for (int i = 0; i < N_TERMS; i++) begin
      s += longint'(samples[i]) * longint'(coefs[i]);
    end
    return ACC_W'(s);
  endfunction

  // Loads one of the stimulus patterns into the sample/coef tables.
  task automatic applyStimulus(input int kind);
    for (int i = 0; i < N_TERMS; i++) begin
      case (kind)
        0: begin samples[i] = 24'sd1; coefs[i] = 12'sd1; end
        1: begin
          samples[i] = (i == 0) ? 24'sh800000 : 24'sd0;
          coefs[i]   = (i == 0) ? 12'sd2047 : 12'sd0;
        end
        2: begin samples[i] = 24'sh7FFFFF; coefs[i] = -12'sd2048; end
        default: begin samples[i] = 24'($urandom); coefs[i] = 12'($urandom); end
      endcase
    end
  endtask

  // Starts one run and observes it; returns latency and side observations.
  task automatic run_once(input bit prestarted, input int pulse_a, input int pulse_b,
                          input bit chain, output int lat, output int done_cnt,
                          output bit overlap, output bit early_change, output bit seq_err);
    logic signed [ACC_W-1:0] pre;
    lat = 0; done_cnt = 0; overlap = 0; early_change = 0; seq_err = 0;
    pre = result;
    if (!prestarted) begin
      @(negedge clk);
      start = 1'b1;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 1; n <= LIMIT; n++) begin
      @(posedge clk);
      #1;
      start = ((n + 1) == pulse_a) || ((n + 1) == pulse_b);
      if (done && busy) overlap = 1'b1;
      if (n < N_TERMS * WORD_W &&
          (int'(sel) != n % WORD_W || int'(term_idx) != n / WORD_W)) seq_err = 1'b1;
      if (done) begin
        done_cnt++;
        if (lat == 0) lat = n;
      end else if (lat == 0 && result !== pre) begin
        early_change = 1'b1;
      end
      if (lat != 0 && chain) begin
        start = 1'b1;
        break;
      end
      if (lat != 0 && n >= lat + 6) break;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    applyStimulus(0);
    #12;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %0b want 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %0b want 0", done); else passes++;
    checks++; if (sel !== 5'd0) $display("[TB] FAIL reset_sel: got %0d want 0", sel); else passes++;
    checks++; if (term_idx !== '0) $display("[TB] FAIL reset_term: got %0d want 0", term_idx); else passes++;
    checks++; if (result !== '0) $display("[TB] FAIL reset_result: got %0d want 0", result); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_all_ones;
    int lat, dc; bit ov, ec, se;
    logic signed [ACC_W-1:0] exp_r;
    applyStimulus(0);
    exp_r = model_result();
    run_once(0, 0, 0, 0, lat, dc, ov, ec, se);
    checks++; if (lat != LATENCY) $display("[TB] FAIL t1_latency: got %0d want %0d", lat, LATENCY); else passes++;
    checks++; if (dc != 1) $display("[TB] FAIL t1_done_count: got %0d want 1", dc); else passes++;
    checks++; if (se) $display("[TB] FAIL t1_sel_sequence: got out-of-order want 0..23 x8"); else passes++;
    checks++; if (ov) $display("[TB] FAIL t1_busy_done_overlap: got 1 want 0"); else passes++;
    checks++; if (ec) $display("[TB] FAIL t1_result_early: got change want hold"); else passes++;
    checks++; if (result !== 39'sd8) $display("[TB] FAIL t1_result: got %0d want 8", result); else passes++;
    checks++; if (result !== exp_r) $display("[TB] FAIL t1_model: got %0d want %0d", result, exp_r); else passes++;
  endtask

  task automatic test_sign_bit;
    int lat, dc; bit ov, ec, se;
    applyStimulus(1);
    run_once(0, 0, 0, 0, lat, dc, ov, ec, se);
    checks++; if (lat != LATENCY) $display("[TB] FAIL t2_latency: got %0d want %0d", lat, LATENCY); else passes++;
    checks++; if (result !== -39'sd17171480576) $display("[TB] FAIL t2_result: got %0d want -17171480576", result); else passes++;
  endtask

  task automatic test_full_scale;
    int lat, dc; bit ov, ec, se;
    applyStimulus(2);
    run_once(0, 0, 0, 0, lat, dc, ov, ec, se);
    checks++; if (result !== -39'sd137438937088) $display("[TB] FAIL t3_result: got %0d want -137438937088", result); else passes++;
    checks++; if (result !== model_result()) $display("[TB] FAIL t3_model: got %0d want %0d", result, model_result()); else passes++;
  endtask

  task automatic test_start_ignored;
    int lat, dc; bit ov, ec, se;
    applyStimulus(0);
    run_once(0, 5, 100, 0, lat, dc, ov, ec, se);
    checks++; if (lat != LATENCY) $display("[TB] FAIL t4_latency: got %0d want %0d", lat, LATENCY); else passes++;
    checks++; if (dc != 1) $display("[TB] FAIL t4_done_count: got %0d want 1", dc); else passes++;
    checks++; if (se) $display("[TB] FAIL t4_sel_sequence: got restarted want uninterrupted"); else passes++;
    checks++; if (result !== 39'sd8) $display("[TB] FAIL t4_result: got %0d want 8", result); else passes++;
  endtask

  task automatic test_reset_mid_run;
    int lat, dc, seen_done; bit ov, ec, se;
    logic signed [ACC_W-1:0] exp_r;
    applyStimulus(3);
    exp_r = model_result();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL t5_busy: got %0b want 0", busy); else passes++;
    checks++; if (sel !== 5'd0) $display("[TB] FAIL t5_sel: got %0d want 0", sel); else passes++;
    checks++; if (result !== '0) $display("[TB] FAIL t5_result: got %0d want 0", result); else passes++;
    seen_done = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done) seen_done++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) seen_done++;
    end
    checks++; if (seen_done != 0) $display("[TB] FAIL t5_no_done: got %0d pulses want 0", seen_done); else passes++;
    run_once(0, 0, 0, 0, lat, dc, ov, ec, se);
    checks++; if (lat != LATENCY) $display("[TB] FAIL t5_latency: got %0d want %0d", lat, LATENCY); else passes++;
    checks++; if (result !== exp_r) $display("[TB] FAIL t5_result_after: got %0d want %0d", result, exp_r); else passes++;
  endtask

  task automatic test_back_to_back;
    int lat, dc; bit ov, ec, se;
    logic signed [ACC_W-1:0] exp_a, exp_b;
    applyStimulus(3);
    exp_a = model_result();
    run_once(0, 0, 0, 1, lat, dc, ov, ec, se);
    checks++; if (result !== exp_a) $display("[TB] FAIL t6_first: got %0d want %0d", result, exp_a); else passes++;
    applyStimulus(3);
    exp_b = model_result();
    run_once(1, 0, 0, 0, lat, dc, ov, ec, se);
    checks++; if (lat != LATENCY) $display("[TB] FAIL t6_latency: got %0d want %0d", lat, LATENCY); else passes++;
    checks++; if (ec) $display("[TB] FAIL t6_hold: got change before done want %0d held", exp_a); else passes++;
    checks++; if (result !== exp_b) $display("[TB] FAIL t6_second: got %0d want %0d", result, exp_b); else passes++;
  endtask

  task automatic test_random;
    int lat, dc; bit ov, ec, se;
    logic signed [ACC_W-1:0] exp_r;
    for (int r = 0; r < 4; r++) begin
      applyStimulus(3);
      exp_r = model_result();
      run_once(0, 0, 0, 0, lat, dc, ov, ec, se);
      checks++; if (result !== exp_r) $display("[TB] FAIL rand%0d_result: got %0d want %0d", r, result, exp_r); else passes++;
      checks++; if (ov) $display("[TB] FAIL rand%0d_overlap: got busy&done want exclusive", r); else passes++;
    end
  endtask

  // Scenario sequence; each task checks its own observations.
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    test_reset();
    test_all_ones();
    test_sign_bit();
    test_full_scale();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
